vector_sequencer: RTL and testbench

Stimulus controller for the packed-operand expression blocks (30-bit `a`/`b` in, 30-bit `y` out, fields 4/5/6 unsigned then 4/5/6 signed). It drives a pseudo-random sequence of operand pairs into one expression block, waits a programmable settle time, and folds each result into a MISR signature. The block sits beside the device under test so two implementations of the same expression can be compared by signature after a fixed vector count.

---
 rtl/vector_sequencer.sv | 125 ++++++++++++
 tb/tb_vector_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/vector_sequencer.sv
// Purpose: stimulus controller driving LFSR operand pairs into an expression block, folding results into a MISR.
// Latency: first vector on a/b one cycle after start; each vector held SETTLE+1 cycles, captured on the last.
// Backpressure: none; start is ignored while busy, abort returns to IDLE in any state, rst overrides all.
//
// Ports:
//   clk, rst          single clock, synchronous active-high reset
//   start, abort      run control (start sampled in IDLE/DONE only; abort wins over start)
//   a, b              registered 30-bit operands to the device under test
//   y_in              30-bit result from the device under test
//   busy, done        status: busy in SETTLE/CAPTURE, done sticky in DONE
//   sig, vec_cnt      registered MISR signature and count of captured vectors
module vector_sequencer #(
    parameter int          NUM_VECTORS = 256,
    parameter int          SETTLE      = 1,
    parameter logic [59:0] SEED        = 60'h0123456789ABCDE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    output logic [29:0] a,
    output logic [29:0] b,
    input  logic [29:0] y_in,
    output logic        busy,
    output logic        done,
    output logic [29:0] sig,
    output logic [15:0] vec_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_CAPTURE,
        S_DONE
    } state_t;

    // With no settle time a freshly driven vector is captured on the very next edge.
    localparam state_t      DRIVE_STATE = (SETTLE == 0) ? S_CAPTURE : S_SETTLE;
    localparam logic [3:0]  TIMER_LOAD  = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);
    localparam logic [15:0] LAST_IDX    = 16'(NUM_VECTORS - 1);

    state_t      state, state_nxt;
    logic [3:0]  timer, timer_nxt;
    logic [59:0] lfsr, lfsr_nxt;
    logic [59:0] ab_nxt;
    logic [29:0] sig_nxt;
    logic [15:0] cnt_nxt;
    logic [59:0] lfsr_step;
    logic        misr_fb;

    assign lfsr_step = {lfsr[58:0], lfsr[59] ^ lfsr[58]};
    assign misr_fb   = sig[29] ^ sig[5] ^ sig[3] ^ sig[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            timer   <= 4'd0;
            lfsr    <= SEED;
            a       <= 30'd0;
            b       <= 30'd0;
            sig     <= 30'd0;
            vec_cnt <= 16'd0;
        end else begin
            state   <= state_nxt;
            timer   <= timer_nxt;
            lfsr    <= lfsr_nxt;
            b       <= ab_nxt[59:30];
            a       <= ab_nxt[29:0];
            sig     <= sig_nxt;
            vec_cnt <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        lfsr_nxt  = lfsr;
        ab_nxt    = {b, a};
        sig_nxt   = sig;
        cnt_nxt   = vec_cnt;

        if (abort) begin
            // Datapath registers keep their values so an aborted run can be inspected.
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        lfsr_nxt  = SEED;
                        ab_nxt    = SEED;
                        sig_nxt   = 30'd0;
                        cnt_nxt   = 16'd0;
                        timer_nxt = TIMER_LOAD;
                        state_nxt = DRIVE_STATE;
                    end
                end
                S_SETTLE: begin
                    if (timer == 4'd0) begin
                        state_nxt = S_CAPTURE;
                    end else begin
                        timer_nxt = timer - 4'd1;
                    end
                end
                S_CAPTURE: begin
                    sig_nxt = {sig[28:0], misr_fb} ^ y_in;
                    cnt_nxt = vec_cnt + 16'd1;
                    if (vec_cnt == LAST_IDX) begin
                        // Last vector: operands stay on the bus, no further LFSR step.
                        state_nxt = S_DONE;
                    end else begin
                        lfsr_nxt  = lfsr_step;
                        ab_nxt    = lfsr_step;
                        timer_nxt = TIMER_LOAD;
                        state_nxt = DRIVE_STATE;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    assign busy = (state == S_SETTLE) || (state == S_CAPTURE);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_vector_sequencer.sv
// Purpose: self-checking bench for vector_sequencer with four parameterisations and a reference MISR model.
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: not applicable; all waits on the device are bounded by cycle budgets.
module tb_vector_sequencer;

    localparam logic [59:0] SEED_A = 60'h0123456789ABCDE;
    localparam logic [59:0] SEED_B = 60'hFEDCBA987654321;

    logic        clk = 1'b0;
    logic        rst_v   [4];
    logic        start_v [4];
    logic        abort_v [4];
    logic [29:0] a_v     [4];
    logic [29:0] b_v     [4];
    logic [29:0] y_v     [4];
    logic        busy_v  [4];
    logic        done_v  [4];
    logic [29:0] sig_v   [4];
    logic [15:0] cnt_v   [4];

    logic [29:0] mask;
    logic [29:0] y3_rand;
    logic        y3_rand_en;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    // Instance 0: y tied low; 1 and 2: loopback of a; 3: a xor a random mask, or noise while idle.
    assign y_v[0] = 30'd0;
    assign y_v[1] = a_v[1];
    assign y_v[2] = a_v[2];
    assign y_v[3] = y3_rand_en ? y3_rand : (a_v[3] ^ mask);

    vector_sequencer #(.NUM_VECTORS(1), .SETTLE(0), .SEED(SEED_A)) u0 (
        .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .abort(abort_v[0]),
        .a(a_v[0]), .b(b_v[0]), .y_in(y_v[0]), .busy(busy_v[0]), .done(done_v[0]),
        .sig(sig_v[0]), .vec_cnt(cnt_v[0]));

    vector_sequencer #(.NUM_VECTORS(1), .SETTLE(2), .SEED(SEED_A)) u1 (
        .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .abort(abort_v[1]),
        .a(a_v[1]), .b(b_v[1]), .y_in(y_v[1]), .busy(busy_v[1]), .done(done_v[1]),
        .sig(sig_v[1]), .vec_cnt(cnt_v[1]));

    vector_sequencer #(.NUM_VECTORS(2), .SETTLE(0), .SEED(SEED_B)) u2 (
        .clk(clk), .rst(rst_v[2]), .start(start_v[2]), .abort(abort_v[2]),
        .a(a_v[2]), .b(b_v[2]), .y_in(y_v[2]), .busy(busy_v[2]), .done(done_v[2]),
        .sig(sig_v[2]), .vec_cnt(cnt_v[2]));

    vector_sequencer u3 (
        .clk(clk), .rst(rst_v[3]), .start(start_v[3]), .abort(abort_v[3]),
        .a(a_v[3]), .b(b_v[3]), .y_in(y_v[3]), .busy(busy_v[3]), .done(done_v[3]),
        .sig(sig_v[3]), .vec_cnt(cnt_v[3]));

    // ---------------- reference model ----------------
    function automatic logic [59:0] vec_at(input logic [59:0] seed, input int k);
        logic [59:0] v;
        v = seed;
        for (int i = 0; i < k; i++) v = {v[58:0], v[59] ^ v[58]};
        return v;
    endfunction

    // mode 0: y=0, mode 1: y=a, mode 2: y=a^m
    function automatic logic [29:0] model_sig(input logic [59:0] seed, input int n,
                                              input int mode, input logic [29:0] m);
        logic [29:0] s;
        logic [29:0] y;
        logic [59:0] v;
        s = 30'd0;
        for (int k = 0; k < n; k++) begin
            v = vec_at(seed, k);
            y = (mode == 0) ? 30'd0 : ((mode == 1) ? v[29:0] : (v[29:0] ^ m));
            s = {s[28:0], s[29] ^ s[5] ^ s[3] ^ s[0]} ^ y;
        end
        return s;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int done_cyc;
        int busy_cycles;

        for (int i = 0; i < 4; i++) begin
            rst_v[i]   = 1'b1;
            start_v[i] = 1'b0;
            abort_v[i] = 1'b0;
        end
        mask       = 30'($urandom);
        y3_rand    = 30'($urandom);
        y3_rand_en = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 4; i++) rst_v[i] = 1'b0;

        // Reset then idle with a noisy y_in: nothing may move.
        for (int c = 0; c < 10; c++) begin
            y3_rand = 30'($urandom);
            tick();
            check("idle_ab", {4'd0, b_v[3], a_v[3]}, 64'd0);
            check("idle_sig_cnt_flags", {16'd0, sig_v[3], cnt_v[3], busy_v[3], done_v[3]}, 64'd0);
        end
        y3_rand_en = 1'b0;

        // N=1, S=0, y=0
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        check("n1s0_ab_c1", {4'd0, b_v[0], a_v[0]}, {4'd0, SEED_A});
        check("n1s0_busy_c1", busy_v[0], 1);
        check("n1s0_done_c1", done_v[0], 0);
        tick();
        check("n1s0_done_c2", done_v[0], 1);
        check("n1s0_busy_c2", busy_v[0], 0);
        check("n1s0_sig", sig_v[0], 0);
        check("n1s0_cnt", cnt_v[0], 1);

        // N=1, S=2, loopback
        start_v[1] = 1'b1;
        tick();
        start_v[1] = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            check("n1s2_busy", busy_v[1], 1);
            check("n1s2_done_early", done_v[1], 0);
            tick();
        end
        check("n1s2_done_c4", done_v[1], 1);
        check("n1s2_busy_c4", busy_v[1], 0);
        check("n1s2_sig", sig_v[1], model_sig(SEED_A, 1, 1, 30'd0));

        // N=2, S=0, loopback
        start_v[2] = 1'b1;
        tick();
        start_v[2] = 1'b0;
        check("n2s0_ab_c1", {4'd0, b_v[2], a_v[2]}, {4'd0, SEED_B});
        tick();
        check("n2s0_ab_c2", {4'd0, b_v[2], a_v[2]}, {4'd0, vec_at(SEED_B, 1)});
        check("n2s0_cnt_c2", cnt_v[2], 1);
        check("n2s0_done_c2", done_v[2], 0);
        tick();
        check("n2s0_done_c3", done_v[2], 1);
        check("n2s0_sig", sig_v[2], model_sig(SEED_B, 2, 1, 30'd0));
        check("n2s0_cnt_c3", cnt_v[2], 2);

        // Default N=256, S=1: ignored restart at cycle 50, abort sampled on the
        // edge ending cycle 101 (after the 50th capture at the edge ending cycle 100).
        repeat ($urandom_range(1, 5)) tick();
        start_v[3] = 1'b1;
        tick();
        start_v[3] = 1'b0;
        check("dflt_ab_c1", {4'd0, b_v[3], a_v[3]}, {4'd0, SEED_A});
        for (int c = 1; c <= 101; c++) begin
            start_v[3] = (c == 50);
            abort_v[3] = (c == 101);
            tick();
        end
        start_v[3] = 1'b0;
        abort_v[3] = 1'b0;
        check("abort_busy", busy_v[3], 0);
        check("abort_done", done_v[3], 0);
        check("abort_cnt", cnt_v[3], 50);
        check("abort_sig", sig_v[3], model_sig(SEED_A, 50, 2, mask));
        check("abort_ab", {4'd0, b_v[3], a_v[3]}, {4'd0, vec_at(SEED_A, 50)});
        tick();
        check("abort_idle_busy", busy_v[3], 0);
        check("abort_idle_cnt", cnt_v[3], 50);

        // Full uninterrupted rerun.
        start_v[3] = 1'b1;
        tick();
        start_v[3] = 1'b0;
        done_cyc    = -1;
        busy_cycles = 0;
        for (int c = 1; c <= 600; c++) begin
            if (done_v[3]) begin
                done_cyc = c;
                break;
            end
            if (busy_v[3]) busy_cycles++;
            tick();
        end
        check("run_done_cycle", 64'(done_cyc), 64'd513);
        check("run_busy_cycles", 64'(busy_cycles), 64'd512);
        check("run_sig", sig_v[3], model_sig(SEED_A, 256, 2, mask));
        check("run_cnt", cnt_v[3], 256);
        repeat (3) tick();
        check("run_done_sticky", done_v[3], 1);
        check("run_sig_hold", sig_v[3], model_sig(SEED_A, 256, 2, mask));

        // Synchronous reset mid-run at cycle 37.
        start_v[3] = 1'b1;
        tick();
        start_v[3] = 1'b0;
        for (int c = 1; c < 37; c++) tick();
        rst_v[3] = 1'b1;
        tick();
        rst_v[3] = 1'b0;
        check("rst_ab", {4'd0, b_v[3], a_v[3]}, 64'd0);
        check("rst_sig", sig_v[3], 0);
        check("rst_cnt", cnt_v[3], 0);
        check("rst_busy", busy_v[3], 0);
        check("rst_done", done_v[3], 0);
        tick();
        check("rst_idle_busy", busy_v[3], 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
